// File: rtl/led_frame_writer.sv
// Pixel-stream / fill writer for a 32x16 LED matrix RAM.
// A one-cycle request stage sits in front of the registered write port.
module led_frame_writer #(
  parameter int unsigned P_COLS  = 32,
  parameter int unsigned P_ROWS  = 16,
  parameter int unsigned P_ROUND = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_sof,
  input  logic [23:0] s_rgb,
  input  logic        fill_req,
  input  logic [23:0] fill_rgb,
  output logic [31:0] data_out,
  output logic        data_out_en,
  output logic        busy,
  output logic        frame_done,
  output logic        sync_err
);

  localparam logic [4:0] LastCol = 5'(P_COLS - 1);
  localparam logic [3:0] LastRow = 4'(P_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFill} state_e;

  // Reset asserts asynchronously and is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  state_e      state_q;
  logic [4:0]  col_q;
  logic [3:0]  row_q;
  logic [4:0]  col_nxt;
  logic [3:0]  row_nxt;
  logic        at_last;
  logic [23:0] fill_color_q;

  // Write request stage, converted and presented on the next edge.
  logic        wr_q;
  logic        wr_last_q;
  logic        err_q;
  logic [8:0]  wr_addr_q;
  logic [23:0] wr_rgb_q;

  assign s_ready = !rst_n || (state_q == StStream) || ((state_q == StIdle) && !fill_req);
  assign busy    = (state_q != StIdle);
  assign at_last = (col_q == LastCol) && (row_q == LastRow);

  always_comb begin
    col_nxt = col_q + 5'd1;
    row_nxt = row_q;
    if (col_q == LastCol) begin
      col_nxt = '0;
      row_nxt = row_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      fill_color_q <= '0;
      wr_q         <= 1'b0;
      wr_last_q    <= 1'b0;
      err_q        <= 1'b0;
      wr_addr_q    <= '0;
      wr_rgb_q     <= '0;
    end else begin
      wr_q      <= 1'b0;
      wr_last_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fill_req) begin
            fill_color_q <= fill_rgb;
            col_q        <= '0;
            row_q        <= '0;
            state_q      <= StFill;
          end else if (s_valid) begin
            if (s_sof) begin
              wr_q      <= 1'b1;
              wr_addr_q <= '0;
              wr_rgb_q  <= s_rgb;
              col_q     <= 5'd1;
              row_q     <= '0;
              state_q   <= StStream;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StStream: begin
          if (s_valid) begin
            wr_q     <= 1'b1;
            wr_rgb_q <= s_rgb;
            if (s_sof) begin
              // Resynchronise: this pixel becomes address 0 of a new frame.
              wr_addr_q <= '0;
              err_q     <= 1'b1;
              col_q     <= 5'd1;
              row_q     <= '0;
            end else begin
              wr_addr_q <= {row_q, col_q};
              if (at_last) begin
                wr_last_q <= 1'b1;
                col_q     <= '0;
                row_q     <= '0;
                state_q   <= StIdle;
              end else begin
                col_q <= col_nxt;
                row_q <= row_nxt;
              end
            end
          end
        end
        StFill: begin
          wr_q      <= 1'b1;
          wr_addr_q <= {row_q, col_q};
          wr_rgb_q  <= fill_color_q;
          if (at_last) begin
            wr_last_q <= 1'b1;
            col_q     <= '0;
            row_q     <= '0;
            state_q   <= StIdle;
          end else begin
            col_q <= col_nxt;
            row_q <= row_nxt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  function automatic logic [3:0] to4(input logic [7:0] c8);
    logic [4:0] r;
    r = 5'(({1'b0, c8} + 9'd8) >> 4);
    if (P_ROUND == 0) begin
      return c8[7:4];
    end
    return r[4] ? 4'hF : r[3:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      data_out_en <= 1'b0;
      frame_done  <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      data_out_en <= wr_q;
      frame_done  <= wr_last_q;
      sync_err    <= err_q;
      if (wr_q) begin
        data_out <= {7'b0, wr_addr_q, 4'b0, to4(wr_rgb_q[7:0]), to4(wr_rgb_q[15:8]),
                     to4(wr_rgb_q[23:16])};
      end
    end
  end

endmodule

// File: tb/tb_led_frame_writer.sv
// Directed bench for led_frame_writer: streaming, fill, framing errors and reset abort.
module tb_led_frame_writer;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic        s_sof;
  logic [23:0] s_rgb;
  logic        fill_req;
  logic [23:0] fill_rgb;
  logic [31:0] data_out;
  logic        data_out_en;
  logic        busy;
  logic        frame_done;
  logic        sync_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] wq[$];
  bit          fdq[$];
  int          serr_cnt = 0;
  int          orphan_fd = 0;

  led_frame_writer #(.P_COLS(32), .P_ROWS(16), .P_ROUND(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_sof      (s_sof),
    .s_rgb      (s_rgb),
    .fill_req   (fill_req),
    .fill_rgb   (fill_rgb),
    .data_out   (data_out),
    .data_out_en(data_out_en),
    .busy       (busy),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobed word away from the active edge.
  always @(negedge clk) begin
    if (data_out_en) begin
      wq.push_back(data_out);
      fdq.push_back(frame_done);
    end else if (frame_done) begin
      orphan_fd++;
    end
    if (sync_err) serr_cnt++;
  end

  function automatic logic [3:0] cv(input logic [7:0] c8);
    int v;
    v = (int'(c8) + 8) / 16;
    if (v > 15) v = 15;
    return 4'(v);
  endfunction

  function automatic logic [31:0] word(input int addr, input logic [23:0] rgb);
    return {7'b0, 9'(addr), 4'b0, cv(rgb[7:0]), cv(rgb[15:8]), cv(rgb[23:16])};
  endfunction

  task automatic clear_log();
    wq.delete();
    fdq.delete();
    serr_cnt  = 0;
    orphan_fd = 0;
  endtask

  task automatic beat(input bit sof, input logic [23:0] rgb);
    s_valid = 1'b1;
    s_sof   = sof;
    s_rgb   = rgb;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    s_valid  = 1'b0;
    s_sof    = 1'b0;
    fill_req = 1'b0;
    reset    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_not_busy(input string name);
    int c;
    for (c = 0; c < 700; c++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout busy=%b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    fill_req = 1'b1;
    s_valid  = 1'b1;
    s_sof    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, data_out_en, frame_done, sync_err, busy, s_ready} !== {32'h0, 5'b00001}) begin
      errors++;
      $display("FAIL reset_outputs got do=%h en=%b fd=%b se=%b busy=%b rdy=%b want 0/0/0/0/0/1",
               data_out, data_out_en, frame_done, sync_err, busy, s_ready);
    end
    fill_req = 1'b0;
    s_valid  = 1'b0;
    s_sof    = 1'b0;
    reset    = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || data_out_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b en=%b want 0 0", busy, data_out_en);
    end
  endtask

  task automatic test_single_beat();
    do_reset();
    clear_log();
    s_valid = 1'b1;
    s_sof   = 1'b1;
    s_rgb   = 24'hFF8000;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got %b want 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    checks++;
    if (data_out_en !== 1'b0) begin
      errors++;
      $display("FAIL beat_latency_early got en=%b want 0", data_out_en);
    end
    @(negedge clk);
    checks++;
    if (data_out !== 32'h0000_008F || data_out_en !== 1'b1) begin
      errors++;
      $display("FAIL beat_word got %h en=%b want 0000008f en=1", data_out, data_out_en);
    end
    @(negedge clk);
    checks++;
    if (data_out !== 32'h0000_008F || data_out_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL beat_hold got %h en=%b busy=%b want 0000008f 0 1", data_out, data_out_en, busy);
    end
  endtask

  task automatic test_full_frame();
    int bad;
    int fds;
    do_reset();
    clear_log();
    for (int i = 0; i < 512; i++) begin
      beat(i == 0, {8'(i), 8'(i * 7), 8'(255 - i)});
      if (i == 100) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL frame_busy got %b want 1", busy);
        end
      end
    end
    idle(4);
    checks++;
    if (wq.size() != 512) begin
      errors++;
      $display("FAIL frame_count got %0d want 512", wq.size());
    end
    bad = 0;
    fds = 0;
    for (int k = 0; k < wq.size() && k < 512; k++) begin
      if (wq[k] !== word(k, {8'(k), 8'(k * 7), 8'(255 - k)})) bad++;
      if (fdq[k]) fds++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_words got %0d bad words want 0", bad);
    end
    if (wq.size() == 512) begin
      checks++;
      if (wq[32][24:16] !== 9'h020) begin
        errors++;
        $display("FAIL frame_beat33_addr got %h want 020", wq[32][24:16]);
      end
      checks++;
      if (fdq[511] !== 1'b1 || fds != 1 || orphan_fd != 0) begin
        errors++;
        $display("FAIL frame_done got last=%b count=%0d orphan=%0d want 1 1 0",
                 fdq[511], fds, orphan_fd);
      end
      checks++;
      if (data_out !== wq[511]) begin
        errors++;
        $display("FAIL frame_hold got %h want %h", data_out, wq[511]);
      end
    end
    checks++;
    if (busy !== 1'b0 || serr_cnt != 0) begin
      errors++;
      $display("FAIL frame_end got busy=%b serr=%0d want 0 0", busy, serr_cnt);
    end
  endtask

  task automatic test_fill();
    int low;
    int bad;
    int fds;
    do_reset();
    clear_log();
    fill_req = 1'b1;
    fill_rgb = 24'h0F1011;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_accept_ready got %b want 0", s_ready);
    end
    @(negedge clk);
    fill_req = 1'b0;
    fill_rgb = 24'hFFFFFF;
    low = 0;
    for (int c = 0; c < 600; c++) begin
      if (!busy) break;
      if (!s_ready) low++;
      @(negedge clk);
    end
    checks++;
    if (low != 512 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready_low got %0d cycles busy=%b want 512 0", low, busy);
    end
    idle(4);
    checks++;
    if (wq.size() != 512) begin
      errors++;
      $display("FAIL fill_count got %0d want 512", wq.size());
    end
    bad = 0;
    fds = 0;
    for (int k = 0; k < wq.size() && k < 512; k++) begin
      if (wq[k] !== {7'b0, 9'(k), 4'b0, 12'h111}) bad++;
      if (fdq[k]) fds++;
    end
    checks++;
    if (bad != 0 || fds != 1 || (wq.size() == 512 && fdq[511] !== 1'b1)) begin
      errors++;
      $display("FAIL fill_words got bad=%0d fd=%0d want 0 1", bad, fds);
    end
  endtask

  task automatic test_sync_err();
    int bad;
    do_reset();
    clear_log();
    beat(1'b0, 24'h123456);
    s_valid = 1'b0;
    checks++;
    if (sync_err !== 1'b0 || data_out_en !== 1'b0) begin
      errors++;
      $display("FAIL nosof_early got se=%b en=%b want 0 0", sync_err, data_out_en);
    end
    @(negedge clk);
    checks++;
    if (sync_err !== 1'b1 || data_out_en !== 1'b0) begin
      errors++;
      $display("FAIL nosof_pulse got se=%b en=%b want 1 0", sync_err, data_out_en);
    end
    idle(3);
    checks++;
    if (wq.size() != 0 || serr_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nosof_result got writes=%0d serr=%0d busy=%b want 0 1 0",
               wq.size(), serr_cnt, busy);
    end

    clear_log();
    for (int i = 0; i < 111; i++) begin
      if (i == 105) begin
        fill_req = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_fill_ignored_ready got %b want 1", s_ready);
        end
      end
      beat(i == 0 || i == 100, 24'h000000);
      fill_req = 1'b0;
    end
    idle(4);
    checks++;
    if (wq.size() != 111) begin
      errors++;
      $display("FAIL resync_count got %0d want 111", wq.size());
    end
    bad = 0;
    for (int k = 0; k < wq.size() && k < 111; k++) begin
      if (wq[k][24:16] !== 9'((k < 100) ? k : k - 100)) bad++;
    end
    checks++;
    if (bad != 0 || serr_cnt != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL resync_result got bad=%0d serr=%0d busy=%b want 0 1 1", bad, serr_cnt, busy);
    end
  endtask

  task automatic test_fill_priority();
    do_reset();
    clear_log();
    fill_req = 1'b1;
    fill_rgb = 24'h000000;
    s_valid  = 1'b1;
    s_sof    = 1'b1;
    s_rgb    = 24'hFFFFFF;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready got %b want 0", s_ready);
    end
    @(negedge clk);
    fill_req = 1'b0;
    s_valid  = 1'b0;
    s_sof    = 1'b0;
    wait_not_busy("prio");
    idle(4);
    checks++;
    if (wq.size() != 512 || serr_cnt != 0 || (wq.size() > 0 && wq[0] !== 32'h0)) begin
      errors++;
      $display("FAIL prio_result got writes=%0d serr=%0d want 512 0", wq.size(), serr_cnt);
    end
  endtask

  task automatic test_reset_mid_fill();
    clear_log();
    fill_req = 1'b1;
    fill_rgb = 24'hFFFFFF;
    @(negedge clk);
    fill_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      #1;
      if (wq.size() >= 200) break;
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({data_out, data_out_en, frame_done, sync_err, busy, s_ready} !== {32'h0, 5'b00001}) begin
      errors++;
      $display("FAIL abort_outputs got do=%h en=%b fd=%b se=%b busy=%b rdy=%b want 0/0/0/0/0/1",
               data_out, data_out_en, frame_done, sync_err, busy, s_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (wq.size() != 200 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop got writes=%0d busy=%b want 200 0", wq.size(), busy);
    end
    beat(1'b0, 24'h00FF00);
    idle(3);
    checks++;
    if (wq.size() != 200 || serr_cnt != 1) begin
      errors++;
      $display("FAIL abort_needs_sof got writes=%0d serr=%0d want 200 1", wq.size(), serr_cnt);
    end
  endtask

  initial begin
    reset    = 1'b0;
    s_valid  = 1'b0;
    s_sof    = 1'b0;
    s_rgb    = '0;
    fill_req = 1'b0;
    fill_rgb = '0;
    test_reset();
    test_single_beat();
    test_full_frame();
    test_fill();
    test_sync_err();
    test_fill_priority();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
